// File: rtl/mont_exp_window.sv
// rtl/mont_exp_window.sv - left-to-right fixed-window Montgomery exponentiation controller
// Computes result = x^e mod m by driving an external Montgomery multiplier.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   start, busy, done      request / in-progress / one-cycle completion pulse
//   x, exponent            base (normal domain) and exponent, latched on start
//   r_mod_m, r2_mod_m      R mod m and R^2 mod m, latched on start
//   result                 x^e mod m, held until the next accepted start
//   mul_start, mul_a/b     multiplier request and operands
//   mul_done, mul_result   multiplier completion pulse and product mont(a,b)
module mont_exp_window #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 1024,
  parameter int WINDOW    = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     r_mod_m,
  input  logic [WIDTH-1:0]     r2_mod_m,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_done,
  input  logic [WIDTH-1:0]     mul_result
);

  localparam int TAB  = 1 << WINDOW;
  localparam int NWIN = EXP_WIDTH / WINDOW;
  localparam int IW   = $clog2(NWIN + 1);
  localparam int SW   = $clog2(WINDOW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TOMONT, S_PRECOMP, S_SCAN, S_SQUARE, S_MULT, S_FROMMONT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]     x_q, r_q, r2_q, acc, result_q;
  logic [EXP_WIDTH-1:0] exp_sh;
  logic [WIDTH-1:0]     tab [TAB];
  logic [IW-1:0]        win_idx;
  logic [SW-1:0]        sq_cnt;
  logic [WINDOW-1:0]    pre_idx;
  logic                 seen_nz, mul_pend;

  logic [WINDOW-1:0] w;
  logic              last_win, mul_cap, sq_last, mul_step;

  // The exponent is shifted left one window per advance, so the current
  // window always sits in the top WINDOW bits.
  assign w        = exp_sh[EXP_WIDTH-1 -: WINDOW];
  assign last_win = (win_idx == IW'(NWIN));
  // A product is only taken while a request is outstanding; stray pulses drop.
  assign mul_cap  = mul_pend & mul_done;
  assign sq_last  = (sq_cnt == SW'(WINDOW - 1));
  assign mul_step = (state_q == S_TOMONT) || (state_q == S_PRECOMP) ||
                    (state_q == S_SQUARE) || (state_q == S_MULT) ||
                    (state_q == S_FROMMONT);

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_TOMONT;
      S_TOMONT:   if (mul_cap) state_d = (WINDOW > 1) ? S_PRECOMP : S_SCAN;
      S_PRECOMP:  if (mul_cap && pre_idx == {WINDOW{1'b1}}) state_d = S_SCAN;
      S_SCAN: begin
        if (last_win)     state_d = S_FROMMONT;
        else if (seen_nz) state_d = S_SQUARE;
      end
      S_SQUARE:   if (mul_cap && sq_last) state_d = (w != '0) ? S_MULT : S_SCAN;
      S_MULT:     if (mul_cap) state_d = S_SCAN;
      S_FROMMONT: if (mul_cap) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    result    = result_q;
    // Each multiply step opens with a request and then waits for its product.
    mul_start = mul_step && !mul_pend;
    mul_a     = '0;
    mul_b     = '0;
    case (state_q)
      S_TOMONT:   begin mul_a = x_q;                       mul_b = r2_q;      end
      S_PRECOMP:  begin mul_a = tab[pre_idx - WINDOW'(1)]; mul_b = tab[1];    end
      S_SQUARE:   begin mul_a = acc;                       mul_b = acc;       end
      S_MULT:     begin mul_a = acc;                       mul_b = tab[w];    end
      S_FROMMONT: begin mul_a = acc;                       mul_b = WIDTH'(1); end
      default:    begin mul_a = '0;                        mul_b = '0;        end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q      <= '0;
      r_q      <= '0;
      r2_q     <= '0;
      acc      <= '0;
      result_q <= '0;
      exp_sh   <= '0;
      win_idx  <= '0;
      sq_cnt   <= '0;
      pre_idx  <= '0;
      seen_nz  <= 1'b0;
      mul_pend <= 1'b0;
      for (int i = 0; i < TAB; i++) tab[i] <= '0;
    end else begin
      if (mul_start)    mul_pend <= 1'b1;
      else if (mul_cap) mul_pend <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          x_q     <= x;
          r_q     <= r_mod_m;
          r2_q    <= r2_mod_m;
          exp_sh  <= exponent;
          tab[0]  <= r_mod_m;
          win_idx <= '0;
          seen_nz <= 1'b0;
          sq_cnt  <= '0;
          pre_idx <= WINDOW'(2);
        end
        S_TOMONT: if (mul_cap) tab[1] <= mul_result;
        S_PRECOMP: if (mul_cap) begin
          tab[pre_idx] <= mul_result;
          pre_idx      <= pre_idx + WINDOW'(1);
        end
        S_SCAN: begin
          if (last_win) begin
            if (!seen_nz) acc <= r_q;
          end else if (!seen_nz) begin
            // Leading zero windows are skipped; the first nonzero one seeds
            // the accumulator straight from the table.
            if (w != '0) begin
              acc     <= tab[w];
              seen_nz <= 1'b1;
            end
            exp_sh  <= exp_sh << WINDOW;
            win_idx <= win_idx + IW'(1);
          end else begin
            sq_cnt <= '0;
          end
        end
        S_SQUARE: if (mul_cap) begin
          acc    <= mul_result;
          sq_cnt <= sq_cnt + SW'(1);
          if (sq_last && w == '0) begin
            exp_sh  <= exp_sh << WINDOW;
            win_idx <= win_idx + IW'(1);
          end
        end
        S_MULT: if (mul_cap) begin
          acc     <= mul_result;
          exp_sh  <= exp_sh << WINDOW;
          win_idx <= win_idx + IW'(1);
        end
        S_FROMMONT: if (mul_cap) result_q <= mul_result;
        default: ;
      endcase
    end
  end

endmodule
